// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared types and constants for the data-memory arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    DARB_IDLE   = 1'b0,
    DARB_SECOND = 1'b1
  } darb_state_t;

  localparam logic LANE0   = 1'b0;
  localparam logic LANE1   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int MEM_ADDR_BUS = 32;
  localparam int DATA_BUS     = 32;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_mux.sv
// ============================================================================
// dmem_lane_mux : selects one lane's access bundle onto the memory port
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_lane_mux
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS,
  parameter int DATA_W = DATA_BUS
) (
  input  logic              sel,
  input  logic              en,
  input  logic              ext_stall,
  input  logic              we0,
  input  logic              we1,
  input  logic [3:0]        wea0,
  input  logic [3:0]        wea1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              mem_w,
  output logic [3:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    mem_w     = DISABLE;
    mem_wea   = 4'h0;
    mem_addr  = (sel == LANE1) ? addr1 : addr0;
    mem_wdata = '0;
    if (en) begin
      mem_wdata = (sel == LANE1) ? wdata1 : wdata0;
      // A stalled store is held back until the stall lifts
      if (!ext_stall) begin
        mem_w   = (sel == LANE1) ? we1 : we0;
        mem_wea = (sel == LANE1) ? wea1 : wea0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : serialises the two lanes' accesses onto one data-memory port
// Revision 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS,
  parameter int DATA_W = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_stall,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [3:0]        wea0,
  input  logic [3:0]        wea1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              num0,
  input  logic              num1,
  output logic              mem_w,
  output logic [3:0]        mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stop,
  output logic [31:0]       conflict_cnt
);

  darb_state_t       state;
  logic              first;
  logic [DATA_W-1:0] hold;
  logic [31:0]       cnt;

  logic              same_word_loads;
  logic              conflict;
  logic              older;
  logic              sel;
  logic              en;
  logic [ADDR_W-1:0] mux_addr;

  // Tags always differ, so num0 alone determines program order
  logic unused_num1;
  assign unused_num1 = num1;

  always_comb begin
    same_word_loads = !we0 && !we1 && (addr0[ADDR_W-1:2] == addr1[ADDR_W-1:2]);
    conflict        = req0 && req1 && !same_word_loads;
    older           = num0 ? LANE1 : LANE0;
    sel             = LANE0;
    en              = DISABLE;
    rdata0          = mem_rdata;
    rdata1          = mem_rdata;
    stop            = ext_stall;

    if (state == DARB_SECOND) begin
      sel = ~first;
      en  = ENABLE;
      if (first == LANE0) rdata0 = hold;
      else                rdata1 = hold;
    end else if (conflict) begin
      sel  = older;
      en   = ENABLE;
      stop = 1'b1;
    end else if (req0 || req1) begin
      sel = req0 ? LANE0 : LANE1;
      en  = ENABLE;
    end

    if (!rst_n) begin
      sel    = LANE0;
      en     = DISABLE;
      stop   = 1'b0;
      rdata0 = '0;
      rdata1 = '0;
    end
  end

  dmem_lane_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lane_mux (
    .sel       (sel),
    .en        (en),
    .ext_stall (ext_stall),
    .we0       (we0),
    .we1       (we1),
    .wea0      (wea0),
    .wea1      (wea1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .mem_w     (mem_w),
    .mem_wea   (mem_wea),
    .mem_addr  (mux_addr),
    .mem_wdata (mem_wdata)
  );

  assign mem_addr     = rst_n ? mux_addr : '0;
  assign conflict_cnt = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DARB_IDLE;
      hold  <= '0;
      first <= LANE0;
      cnt   <= '0;
    end else begin
      case (state)
        DARB_IDLE: begin
          if (conflict && !ext_stall) begin
            state <= DARB_SECOND;
            hold  <= mem_rdata;
            first <= older;
            cnt   <= sat_inc(cnt);
          end
        end
        DARB_SECOND: begin
          if (!ext_stall) state <= DARB_IDLE;
        end
        default: state <= DARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : scoreboard bench with an in-order memory reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int NW = 256;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lane_t;

  typedef struct packed {
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] cnt;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_stall = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        num0 = 1'b0, num1 = 1'b1;
  logic [3:0]  wea0 = 4'h0, wea1 = 4'h0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        mem_w, stop;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata0, rdata1, conflict_cnt;

  logic [31:0] tbmem     [NW];
  logic [31:0] model_mem [NW];
  logic [31:0] model_cnt = '0;
  wb_t         wb_q[$];
  wr_t         wr_q[$];
  bit          mon_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wea0(wea0), .wea1(wea1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .num0(num0), .num1(num1),
    .mem_w(mem_w), .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata0(rdata0), .rdata1(rdata1),
    .stop(stop), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Environment memory: combinational read, byte-enabled write on the edge
  assign mem_rdata = tbmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) tbmem[i] <= init_word(i);
    end else if (mem_w) begin
      for (int b = 0; b < 4; b++)
        if (mem_wea[b]) tbmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) model_mem[i] = init_word(i);
    model_cnt = '0;
  endtask

  // Monitor: pops an expected write for every issued store and an expected
  // write-back for every cycle the pipeline advances.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("write_under_stall", 32'(mem_w & ext_stall), 32'd0);
      if (mem_w && !ext_stall) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %h expected none", mem_addr);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.wdata);
          check("wr_wea", 32'(mem_wea), 32'(e.wea));
        end
      end
      if (!stop) begin
        if (wb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_writeback: got stop=0 expected stop=1");
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          check("rdata0", rdata0, w.r0);
          check("rdata1", rdata1, w.r1);
          check("conflict_cnt", conflict_cnt, w.cnt);
        end
      end
    end
  end

  function automatic lane_t mk_lane(input logic rq, input logic w, input logic [3:0] e,
                                    input logic [31:0] a, input logic [31:0] d);
    lane_t l;
    l.req = rq; l.we = w; l.wea = e; l.addr = a; l.wdata = d;
    return l;
  endfunction

  function automatic lane_t rand_lane();
    lane_t l;
    l.req   = ($urandom_range(0, 3) != 0);
    l.we    = 1'($urandom_range(0, 1));
    l.wea   = l.we ? 4'($urandom_range(1, 15)) : 4'h0;
    l.addr  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    l.wdata = $urandom;
    return l;
  endfunction

  // Executes the pair in program order on the model memory, queues the
  // expected memory writes and write-back, then drives it until it retires.
  task automatic do_pair(input lane_t l0, input lane_t l1, input logic n0,
                         input logic [7:0] pat, input bit rnd);
    lane_t       ln[2];
    logic [31:0] res[2];
    int          ord[2];
    int          l, remaining;
    bit          both, conf, done;
    ln[0] = l0; ln[1] = l1;
    ord[0] = n0 ? 1 : 0;
    ord[1] = n0 ? 0 : 1;
    res[0] = model_mem[l0.addr[9:2]];
    res[1] = res[0];
    for (int k = 0; k < 2; k++) begin
      l = ord[k];
      if (ln[l].req) begin
        res[l] = model_mem[ln[l].addr[9:2]];
        if (ln[l].we) begin
          wr_q.push_back({ln[l].addr, ln[l].wdata, ln[l].wea});
          for (int b = 0; b < 4; b++)
            if (ln[l].wea[b]) model_mem[ln[l].addr[9:2]][8*b +: 8] = ln[l].wdata[8*b +: 8];
        end
      end
    end
    both = l0.req && l1.req;
    conf = both && (l0.we || l1.we || (l0.addr[31:2] != l1.addr[31:2]));
    if (!both && l1.req) res[0] = res[1];
    if (!both && l0.req) res[1] = res[0];
    if (conf) model_cnt = sat_inc(model_cnt);
    wb_q.push_back({res[0], res[1], model_cnt});

    req0 = l0.req; we0 = l0.we; wea0 = l0.wea; addr0 = l0.addr; wdata0 = l0.wdata;
    req1 = l1.req; we1 = l1.we; wea1 = l1.wea; addr1 = l1.addr; wdata1 = l1.wdata;
    num0 = n0; num1 = ~n0;
    remaining = conf ? 2 : 1;
    done = 1'b0;
    for (int c = 0; c < 24 && !done; c++) begin
      ext_stall = rnd ? ($urandom_range(0, 3) == 0) : ((c < 8) ? pat[c] : 1'b0);
      @(negedge clk);
      check("stop", 32'(stop), 32'(ext_stall || (remaining == 2)));
      if (!ext_stall) remaining--;
      done = (remaining == 0);
      @(posedge clk); #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL pair_timeout: got still busy expected retired");
    end
  endtask

  initial begin
    // Reset with an active conflicting store pair and a stall on the inputs
    req0 = 1; we0 = 1; wea0 = 4'hF; addr0 = 32'h44; wdata0 = 32'h55;
    req1 = 1; we1 = 1; wea1 = 4'h3; addr1 = 32'h48; wdata1 = 32'h66;
    ext_stall = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_mem_w", 32'(mem_w), 32'd0);
    check("rst_mem_wea", 32'(mem_wea), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_cnt", conflict_cnt, 32'd0);
    check("rst_hold", dut.hold, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; ext_stall = 0;
    model_reset();
    mon_en = 1;

    // Single lane: store a marker word, then load it back on lane 1
    do_pair(mk_lane(0, 0, 4'h0, 32'h0, 32'h0), mk_lane(1, 1, 4'hF, 32'h100, 32'hDEADBEEF), 0, 8'h0, 0);
    do_pair(mk_lane(0, 0, 4'h0, 32'h0, 32'h0), mk_lane(1, 0, 4'h0, 32'h100, 32'h0), 0, 8'h0, 0);
    // Older store on lane 1, younger load of the same word on lane 0
    do_pair(mk_lane(1, 0, 4'h0, 32'h40, 32'h0), mk_lane(1, 1, 4'hF, 32'h40, 32'h11223344), 1, 8'h0, 0);
    // Same-word loads retire in one cycle
    do_pair(mk_lane(1, 0, 4'h0, 32'h80, 32'h0), mk_lane(1, 0, 4'h0, 32'h82, 32'h0), 0, 8'h0, 0);
    // Stall held for three cycles while in the second access
    do_pair(mk_lane(1, 0, 4'h0, 32'h8, 32'h0), mk_lane(1, 1, 4'hF, 32'hC, 32'hCAFEF00D), 0, 8'b0000_1110, 0);

    for (int i = 0; i < 400; i++)
      do_pair(rand_lane(), rand_lane(), 1'($urandom_range(0, 1)), 8'h0, 1);

    // Reset while the younger store is pending
    check("queues_drained_before_reset", 32'(wb_q.size() + wr_q.size()), 32'd0);
    mon_en = 0;
    ext_stall = 0;
    req0 = 1; we0 = 0; wea0 = 4'h0; addr0 = 32'h10; num0 = 0;
    req1 = 1; we1 = 1; wea1 = 4'hF; addr1 = 32'h20; wdata1 = 32'h12345678; num1 = 1;
    @(negedge clk);
    check("mid_first_stop", 32'(stop), 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_mem_w", 32'(mem_w), 32'd0);
    check("mid_rst_stop", 32'(stop), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_state", 32'(dut.state), 32'(DARB_IDLE));
    check("mid_rst_hold", dut.hold, 32'd0);
    check("mid_rst_cnt", conflict_cnt, 32'd0);
    rst_n = 1;
    req0 = 0; req1 = 0;
    model_reset();
    mon_en = 1;

    // Counter saturation from a preloaded value
    force dut.cnt = 32'hFFFF_FFFE;
    #1 release dut.cnt;
    model_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++)
      do_pair(mk_lane(1, 0, 4'h0, 32'h4, 32'h0), mk_lane(1, 0, 4'h0, 32'h8, 32'h0), 0, 8'h0, 0);
    @(negedge clk);
    check("cnt_saturated", conflict_cnt, 32'hFFFF_FFFF);
    check("queues_drained", 32'(wb_q.size() + wr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the two parallel execution lanes of the dual-issue core. Each lane's mem stage presents its access combinationally. When only one lane accesses memory, the arbiter passes it straight through. When both do, it serialises them in program order (by `num`), stalls the lane pipeline registers for one cycle, and holds the first lane's read data until both lanes write back together.

## Interface
Parameters:
- `ADDR_W`, default 32: data-memory address width.
- `DATA_W`, default 32: data width. Fixed at 32; byte enables are 4 bits.

Ports (clock and reset first):
- `clk`  in  1  core clock. All state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ext_stall`  in  1  stall request from elsewhere in the pipeline.
- `req0`, `req1`  in  1  lane 0 / lane 1 has a memory access this cycle.
- `we0`, `we1`  in  1  access is a store.
- `wea0`, `wea1`  in  4  store byte enables, already shifted for `addr[1:0]`.
- `addr0`, `addr1`  in  ADDR_W  byte address.
- `wdata0`, `wdata1`  in  DATA_W  store data, unshifted.
- `num0`, `num1`  in  1  program-order tag. 0 is the older instruction; the two tags always differ.
- `mem_w`  out  1  memory write strobe.
- `mem_wea`  out  4  memory byte enables.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, combinational from `mem_addr`.
- `rdata0`, `rdata1`  out  DATA_W  raw word returned to each lane.
- `stop`  out  1  pipeline-register hold for both lanes.
- `conflict_cnt`  out  32  saturating count of serialised pairs.

## Operation
- **FSM states:** IDLE and SECOND.
- **Conflict:** `req0 & req1`, unless both are loads (`!we0 & !we1`) to the same word (`addr0[ADDR_W-1:2] == addr1[ADDR_W-1:2]`).
  - The same-word load pair is served in one cycle from one read. No stall.
- **IDLE, no conflict:**
  - The requesting lane (if any) drives the memory outputs. If neither lane requests, `mem_w=0`, `mem_wea=0`, `mem_addr=addr0`, `mem_wdata=0`.
  - `rdata0 = rdata1 = mem_rdata`.
  - `stop = ext_stall`.
- **IDLE, conflict:**
  - The older lane (num==0) drives the memory outputs.
  - `mem_rdata` is captured into `hold` and the older lane id into `first`.
  - `stop = 1`, and the FSM moves to SECOND, unless `ext_stall` is high. In that case the FSM stays in IDLE and issues no write.
- **SECOND:**
  - The younger lane drives the memory outputs.
  - The older lane's `rdata` comes from `hold`; the younger lane's comes from `mem_rdata`.
  - `stop = ext_stall`.
  - Return to IDLE when `!ext_stall`. Otherwise stay in SECOND; `hold` is kept.
- **Writes under stall:** whenever `ext_stall=1`, `mem_w=0` and `mem_wea=0`. The stalled store is issued on the cycle `ext_stall` drops.
- **Store ordering:** for an older store and younger load to the same word, the store executes in the IDLE cycle and the load in SECOND, so the load sees the stored data.
- **`conflict_cnt`:** increments on each IDLE→SECOND transition and saturates at 0xFFFF_FFFF.
- **Reset values (while `rst_n=0`):**
  - State registers: state=IDLE, `hold=0`, `first=0`, `conflict_cnt=0`.
  - Outputs: `stop=0`, `mem_w=0`, `mem_wea=0`, `mem_addr=0`, `mem_wdata=0`, `rdata0=rdata1=0`.
  - Reset in SECOND aborts the second access; no write is issued.

## Timing
- Memory outputs, `rdata*` and `stop` are combinational from the lane inputs and state. Zero added latency on non-conflicting accesses.
- A conflicting pair costs exactly 1 extra cycle (2 cycles total) when `ext_stall` stays low.
- Both lanes' write-back data is valid together in the final cycle of the pair.
- Lane inputs must be held stable while `stop=1`. The pipeline register guarantees this.

## Structure
- Shared package / `def.vh`:
  - FSM state encodings `DARB_IDLE`, `DARB_SECOND`.
  - Lane ids `LANE0`, `LANE1`.
  - Existing `MEM_ADDR_BUS`, `DATA_BUS`, `ENABLE`/`DISABLE`.
- One sub-module, `dmem_lane_mux`: a combinational 2:1 select of the {we, wea, addr, wdata} bundle, gated by `ext_stall`.
- The FSM, `hold` register and counter stay in the top module.

## Test plan
- **Single lane:** `req1` only, load addr 0x100, `mem_rdata=0xDEADBEEF` → `stop=0`; `rdata1=0xDEADBEEF` in the same cycle; `conflict_cnt=0`.
- **Store/load pair:** lane1 older store addr 0x40 data 0x11223344 wea 0xF; lane0 younger load addr 0x40.
  - Cycle 1: `mem_w=1`, `mem_addr=0x40`, `stop=1`.
  - Cycle 2: `mem_w=0`, `rdata0=0x11223344`, `stop=0`, `conflict_cnt=1`.
- **Same-word loads:** both lanes load, addr 0x80 and 0x82 → single cycle, `stop=0`, both `rdata=mem_rdata`.
- **External stall:** conflict with `ext_stall` high in the SECOND cycle for 3 cycles → the FSM stays in SECOND, `mem_w=0` throughout, `hold` unchanged; the younger store is issued on the cycle `ext_stall` drops.
- **Reset mid-pair:** `rst_n=0` during SECOND → next cycle state=IDLE, `stop=0`, `hold=0`, `conflict_cnt=0`, no write issued.
- **Counter saturation:** preload `conflict_cnt` to 0xFFFF_FFFE, run 3 conflicting pairs → reads 0xFFFF_FFFF.
